msg_print_ctrl: RTL and testbench
=================================

Name: msg_print_ctrl

Overview:
Sequencer that streams one fixed-length message out of the 12-byte message ROM (three 4-byte messages: " 0\n\r", " 1\n\r", " X\n\r") into the serial transmitter. A requester picks a message index over a valid/ready handshake. The block then drives the ROM address, waits out the ROM read latency and hands each byte to the UART TX with the TX busy/block flow control. It sits between the status/decision logic and the shared ROM + serial_tx pair, and is the only master of both.

Parameters:
MSG_LEN, 4, bytes per message; message k occupies ROM addresses k*MSG_LEN .. k*MSG_LEN+MSG_LEN-1
NUM_MSG, 3, number of valid message indices (0..NUM_MSG-1)
ADDR_W, 5, ROM address width
CNT_W, 16, width of sent-message counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  message request strobe/level
req_sel  in  2  message index for the request
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
rom_addr  out  ADDR_W  address to message ROM
rom_data  in  8  ROM read data (registered inside ROM, valid one full clk after rom_addr changes)
tx_data  out  8  byte to transmitter
new_tx_data  out  1  single-cycle send strobe
tx_busy  in  1  transmitter busy
tx_block  in  1  host flow-control block; no new byte while high
busy  out  1  high from accept until last byte handed off
done  out  1  one-cycle pulse after last byte of a message is handed off
err  out  1  one-cycle pulse on rejected request (req_sel >= NUM_MSG)
msg_count  out  CNT_W  number of completed messages, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any state): state=IDLE, rom_addr=0, tx_data=0, new_tx_data=0, busy=0, done=0, err=0, msg_count=0, byte index=0. A message in flight is abandoned with no further strobes; the partially sent message is not counted.
- States: IDLE, FETCH, WAIT, SEND, HOLD.
- IDLE: req_ready=1. On req_valid: if req_sel < NUM_MSG, latch base=req_sel*MSG_LEN, byte idx=0, rom_addr=base, busy=1, go FETCH. Otherwise pulse err for 1 cycle and stay IDLE, with req_ready remaining high.
- FETCH: rom_addr stable; one cycle to cover the ROM's registered read; go WAIT.
- WAIT: capture rom_data into tx_data; go SEND.
- SEND: when tx_busy==0 && tx_block==0, assert new_tx_data for exactly this cycle and go HOLD. Otherwise stall in SEND with tx_data held and no strobe.
- HOLD: one cycle guard so the transmitter's busy can rise. Then, if idx==MSG_LEN-1: pulse done, increment msg_count, busy=0, go IDLE. Else idx+1, rom_addr+1, go FETCH.
- Minimum latency: accept to first new_tx_data = 3 cycles. Byte-to-byte spacing is at least 4 cycles plus the transmitter's busy time.
- new_tx_data is never high on two consecutive cycles. It is never high while tx_busy or tx_block is high in the same cycle.
- req_valid is ignored outside IDLE; requesters hold req_valid until they see req_ready.
- rom_addr never exceeds NUM_MSG*MSG_LEN-1 while busy.
- tx_block asserted mid-message: stall in SEND only; no byte is skipped or repeated.
- done and err are never high in the same cycle. done occurs in the cycle busy falls.

Test Plan:
- Reset, then req_sel=1 with tx_busy=0 -> new_tx_data strobes with tx_data 0x20, 0x31, 0x0A, 0x0D in order; rom_addr 4..7; done pulses once; msg_count=1; req_ready returns high.
- req_sel=2 while tx_busy is held high for 20 cycles after each strobe -> bytes 0x20, 0x58, 0x0A, 0x0D; exactly 4 strobes; no strobe while tx_busy=1.
- req_sel=3 -> err high for 1 cycle, no strobe, busy stays 0, msg_count unchanged.
- req_sel=0 with tx_block raised after the 2nd byte for 50 cycles -> stall; on release, bytes 0x0A and 0x0D follow; total 4 strobes.
- Async rst asserted mid-message after the 2nd byte -> all outputs immediately 0, msg_count=0. A new req_sel=0 then sends 0x20, 0x30, 0x0A, 0x0D cleanly.
- 3 back-to-back requests (0, 1, 2) with req_valid held -> each is accepted only when req_ready=1; 12 bytes sent in order; msg_count=3.

Source files
------------

// File: rtl/msg_print_ctrl_if.sv
// msg_print_ctrl_if: request, ROM and transmitter signals of the message print sequencer
// Ports: req_valid/req_sel/req_ready request handshake; rom_addr/rom_data ROM read;
// tx_data/new_tx_data/tx_busy/tx_block transmitter; busy/done/err/msg_count status.
// master is the sequencer side, slave is the requester/ROM/transmitter side.
interface msg_print_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              req_valid;
  logic [1:0]        req_sel;
  logic              req_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_data;
  logic              new_tx_data;
  logic              tx_busy;
  logic              tx_block;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  msg_count;
  modport master (
    input  req_valid, req_sel, rom_data, tx_busy, tx_block,
    output req_ready, rom_addr, tx_data, new_tx_data, busy, done, err, msg_count
  );
  modport slave (
    output req_valid, req_sel, rom_data, tx_busy, tx_block,
    input  req_ready, rom_addr, tx_data, new_tx_data, busy, done, err, msg_count
  );
endinterface

// File: rtl/msg_print_ctrl.sv
// msg_print_ctrl: streams one MSG_LEN-byte message from the message ROM into the serial transmitter
// Ports: clk, rst (async, active-high); bus (master modport): request handshake in,
// ROM address out / data in, transmitter byte + strobe out with busy/block flow control in,
// busy/done/err status and completed-message count out.
module msg_print_ctrl #(
  parameter int MSG_LEN = 4,
  parameter int NUM_MSG = 3,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  msg_print_ctrl_if.master bus
);
  localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, HOLD} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_ok, accept, fire, last, step;
  assign sel_ok = int'(bus.req_sel) < NUM_MSG;
  assign accept = state_q == IDLE && bus.req_valid && sel_ok;
  // the strobe is combinational so it can never coincide with busy or block
  assign fire   = state_q == SEND && !bus.tx_busy && !bus.tx_block;
  assign last   = idx_q == IW'(MSG_LEN - 1);
  assign step   = state_q == HOLD && !last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? FETCH : IDLE;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = SEND;
      SEND:    state_d = fire ? HOLD : SEND;
      HOLD:    state_d = last ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    addr_d = accept ? ADDR_W'(bus.req_sel) * ADDR_W'(MSG_LEN) : step ? addr_q + 1'b1 : addr_q;
    idx_d  = accept ? '0 : step ? idx_q + 1'b1 : idx_q;
    data_d = state_q == WAIT ? bus.rom_data : data_q;
    done_d = state_q == HOLD && last;
    busy_d = accept || (busy_q && !done_d);
    err_d  = state_q == IDLE && bus.req_valid && !sel_ok;
    cnt_d  = cnt_q + CNT_W'(done_d);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      idx_q  <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end
  assign bus.req_ready   = state_q == IDLE;
  assign bus.new_tx_data = fire;
  assign bus.rom_addr    = addr_q;
  assign bus.tx_data     = data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.msg_count   = cnt_q;
endmodule

// File: tb/tb_msg_print_ctrl.sv
// tb_msg_print_ctrl: randomized self-checking bench for msg_print_ctrl against a byte-queue reference
module tb_msg_print_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  msg_print_ctrl_if ifc ();
  msg_print_ctrl dut (.clk(clk), .rst(rst), .bus(ifc));
  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] exp_byte(input int k, input int i);
    return i == 0 ? 8'h20 : i == 1 ? (k == 2 ? 8'h58 : 8'(8'h30 + k)) : i == 2 ? 8'h0A : 8'h0D;
  endfunction
  string      msgs[3] = '{" 0\n\r", " 1\n\r", " X\n\r"};
  logic [7:0] rom[12];
  logic [7:0] exp_q[$];
  int         exp_a[$];
  int         exp_cnt = 0;
  int         strobes = 0;
  int         dones = 0;
  int         busy_len = 0;
  bit         rnd_block = 0;
  logic       prev_strobe = 1'b0;
  task automatic expect_msg(input int k);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_byte(k, i));
      exp_a.push_back(k * 4 + i);
    end
    exp_cnt++;
  endtask
  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) rom[k*4+i] = msgs[k][i];
    forever begin
      @(posedge clk);
      #1 ifc.rom_data = int'(ifc.rom_addr) < 12 ? rom[int'(ifc.rom_addr)] : 8'h00;
    end
  end
  initial forever begin
    @(negedge clk);
    if (ifc.new_tx_data && busy_len > 0 && !rst) begin
      @(posedge clk);
      #1 ifc.tx_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 ifc.tx_busy = 1'b0;
    end
  end
  initial forever begin
    @(posedge clk);
    #1 if (rnd_block) ifc.tx_block = ($urandom_range(0, 3) == 0);
  end
  initial forever begin
    @(negedge clk);
    if (rst) prev_strobe = 1'b0;
    else begin
      chk("invariants",
          {31'd0, (ifc.new_tx_data && (ifc.tx_busy || ifc.tx_block || prev_strobe)) ||
                  (ifc.done && (ifc.err || ifc.busy)) || (ifc.busy && ifc.rom_addr > 5'd11)}, 0);
      if (ifc.new_tx_data) begin
        strobes++;
        chk("strobe_expected", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          chk("tx_data", {24'd0, ifc.tx_data}, {24'd0, exp_q.pop_front()});
          chk("rom_addr", {27'd0, ifc.rom_addr}, exp_a.pop_front());
        end
      end
      if (ifc.done) dones++;
      prev_strobe = ifc.new_tx_data;
    end
  end
  task automatic send_req(input int s);
    int n = 0;
    ifc.req_sel = 2'(s);
    ifc.req_valid = 1'b1;
    @(negedge clk);
    while (!ifc.req_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("req_accept_bound", {31'd0, n < 500}, 1);
    if (s < 3) expect_msg(s);
    @(posedge clk);
    #1 ifc.req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ifc.busy || exp_q.size() > 0) && n < 5000);
    chk("idle_bound", {31'd0, n < 5000}, 1);
    repeat (2) @(negedge clk);
  endtask
  task automatic count_strobes(input int want, input int limit, output int got);
    got = 0;
    for (int c = 0; c < limit && got < want; c++) begin
      @(negedge clk);
      if (ifc.new_tx_data) got++;
    end
  endtask
  initial begin
    int n, d0, s0, c0, got;
    ifc.req_valid = 1'b0;
    ifc.req_sel   = 2'd0;
    ifc.tx_busy   = 1'b0;
    ifc.tx_block  = 1'b0;
    ifc.rom_data  = 8'h00;
    #2 rst = 1'b1;
    #2;
    chk("rst_addr_data", {19'd0, ifc.rom_addr, ifc.tx_data}, 0);
    chk("rst_flags", {28'd0, ifc.new_tx_data, ifc.busy, ifc.done, ifc.err}, 0);
    chk("rst_count", {16'd0, ifc.msg_count}, 0);
    chk("rst_ready", {31'd0, ifc.req_ready}, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    d0 = dones;
    send_req(1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.new_tx_data && n < 10);
    chk("first_latency", n, 3);
    wait_idle();
    chk("sel1_done_once", dones - d0, 1);
    chk("sel1_count", {16'd0, ifc.msg_count}, exp_cnt);
    chk("sel1_ready_back", {31'd0, ifc.req_ready}, 1);
    @(posedge clk);
    #1 busy_len = 20;
    s0 = strobes;
    send_req(2);
    wait_idle();
    chk("sel2_strobes", strobes - s0, 4);
    chk("sel2_count", {16'd0, ifc.msg_count}, exp_cnt);
    @(posedge clk);
    #1 busy_len = 0;
    s0 = strobes;
    c0 = exp_cnt;
    send_req(3);
    @(negedge clk);
    chk("bad_sel_err", {31'd0, ifc.err}, 1);
    chk("bad_sel_busy", {31'd0, ifc.busy}, 0);
    @(negedge clk);
    chk("bad_sel_err_pulse", {31'd0, ifc.err}, 0);
    chk("bad_sel_ready", {31'd0, ifc.req_ready}, 1);
    repeat (6) @(negedge clk);
    chk("bad_sel_no_strobe", strobes - s0, 0);
    chk("bad_sel_count", {16'd0, ifc.msg_count}, c0);
    @(posedge clk);
    #1 s0 = strobes;
    send_req(0);
    count_strobes(2, 200, got);
    chk("block_pre_strobes", got, 2);
    @(posedge clk);
    #1 ifc.tx_block = 1'b1;
    count_strobes(1, 50, got);
    chk("block_stall", got, 0);
    @(posedge clk);
    #1 ifc.tx_block = 1'b0;
    wait_idle();
    chk("block_strobes", strobes - s0, 4);
    @(posedge clk);
    #1 busy_len = 3;
    send_req(0);
    count_strobes(2, 200, got);
    chk("rst_pre_strobes", got, 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_addr_data", {19'd0, ifc.rom_addr, ifc.tx_data}, 0);
    chk("async_rst_flags", {28'd0, ifc.new_tx_data, ifc.busy, ifc.done, ifc.err}, 0);
    chk("async_rst_count", {16'd0, ifc.msg_count}, 0);
    exp_q.delete();
    exp_a.delete();
    exp_cnt = 0;
    busy_len = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 s0 = strobes;
    send_req(0);
    wait_idle();
    chk("post_rst_strobes", strobes - s0, 4);
    chk("post_rst_count", {16'd0, ifc.msg_count}, exp_cnt);
    @(posedge clk);
    #1 s0 = strobes;
    for (int s = 0; s < 3; s++) send_req(s);
    wait_idle();
    chk("b2b_strobes", strobes - s0, 12);
    chk("b2b_count", {16'd0, ifc.msg_count}, exp_cnt);
    @(posedge clk);
    #1 rnd_block = 1'b1;
    for (int r = 0; r < 25; r++) begin
      int s;
      s = $urandom_range(0, 3);
      busy_len = $urandom_range(0, 6);
      send_req(s);
      if (s == 3) begin
        @(negedge clk);
        chk("rand_err", {31'd0, ifc.err}, 1);
        @(posedge clk);
        #1;
      end
    end
    rnd_block = 1'b0;
    @(posedge clk);
    #2 ifc.tx_block = 1'b0;
    wait_idle();
    chk("rand_count", {16'd0, ifc.msg_count}, exp_cnt);
    chk("rand_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
